// File: rtl/pll_pkg.sv
// pll_pkg: constants and state encoding shared by the reference-clock generator
// and its phase timer.
//   N_W        width of period values (matches the PLL multiplication-factor width)
//   S_W        width of phase-step length / stretch accumulator
//   DEFAULT_N  period in clk cycles after reset
//   MIN_PERIOD smallest period that still has one high and one low cycle
package pll_pkg;

    localparam int unsigned N_W        = 15;
    localparam int unsigned S_W        = 8;
    localparam int unsigned DEFAULT_N  = 10;
    localparam int unsigned MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StStretch
    } state_t;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter timing one phase (high, low or stretch).
//   clk       system clock
//   reset     synchronous reset, active-high
//   load      load load_val into the counter this cycle
//   load_val  phase length minus one
//   done      counter has reached zero (last cycle of the current phase)
module phase_timer
    import pll_pkg::*;
#(
    parameter int unsigned W = N_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/ref_clk_gen.sv
// ref_clk_gen: programmable square-wave reference for the PLL, period in clk cycles.
//   clk         system clock
//   reset       synchronous reset, active-high
//   enable      high = generate, low = park fref low
//   period_n    requested period, captured on load (values below 2 clamp to 2)
//   load        strobe: capture period_n as pending
//   step_req    strobe: add step_len extra low cycles to the stretch accumulator
//   step_len    phase-step length
//   fref        generated reference (registered)
//   rise        strobe on the first high cycle of each period
//   period_ack  strobe: pending period became active (coincides with rise)
//   pend        a period update is pending
module ref_clk_gen #(
    parameter int unsigned N_W       = pll_pkg::N_W,
    parameter int unsigned DEFAULT_N = pll_pkg::DEFAULT_N,
    parameter int unsigned S_W       = pll_pkg::S_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [N_W-1:0] period_n,
    input  logic           load,
    input  logic           step_req,
    input  logic [S_W-1:0] step_len,
    output logic           fref,
    output logic           rise,
    output logic           period_ack,
    output logic           pend
);

    import pll_pkg::*;

    state_t         state;
    logic [N_W-1:0] period;
    logic [N_W-1:0] pend_val;
    logic [N_W-1:0] p_next;
    logic [N_W-1:0] hi_len;
    logic [N_W-1:0] lo_len;
    logic [N_W-1:0] load_clamped;
    logic [N_W-1:0] tmr_val;
    logic [S_W-1:0] acc;
    logic [S_W-1:0] acc_base;
    logic [S_W-1:0] acc_next;
    logic [S_W:0]   acc_sum;
    logic           go_high;
    logic           go_low;
    logic           go_stretch;
    logic           tmr_load;
    logic           tmr_done;

    phase_timer #(
        .W (N_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        // Period that will govern the next high phase if we enter HIGH now.
        p_next       = pend ? pend_val : period;
        hi_len       = p_next - (p_next >> 1);
        lo_len       = period >> 1;
        load_clamped = (period_n < N_W'(MIN_PERIOD)) ? N_W'(MIN_PERIOD) : period_n;

        go_high    = 1'b0;
        go_low     = 1'b0;
        go_stretch = 1'b0;
        if (enable) begin
            unique case (state)
                StIdle:    go_high = 1'b1;
                StHigh:    go_low  = tmr_done;
                StLow: begin
                    if (tmr_done) begin
                        if (acc != '0) go_stretch = 1'b1;
                        else           go_high    = 1'b1;
                    end
                end
                StStretch: go_high = tmr_done;
            endcase
        end

        tmr_load = go_high | go_low | go_stretch;
        tmr_val  = '0;
        if (go_high)         tmr_val = hi_len - N_W'(1);
        else if (go_low)     tmr_val = lo_len - N_W'(1);
        else if (go_stretch) tmr_val = N_W'(acc) - N_W'(1);

        // The accumulator is handed to the timer on stretch entry, so steps
        // arriving during the stretch build up for the following period.
        acc_base = go_stretch ? '0 : acc;
        acc_next = acc_base;
        acc_sum  = '0;
        if (step_req && (step_len != '0)) begin
            acc_sum  = {1'b0, acc_base} + {1'b0, step_len};
            acc_next = acc_sum[S_W] ? '1 : acc_sum[S_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            fref       <= 1'b0;
            rise       <= 1'b0;
            period_ack <= 1'b0;
            pend       <= 1'b0;
            pend_val   <= '0;
            period     <= N_W'(DEFAULT_N);
            acc        <= '0;
        end else begin
            rise       <= 1'b0;
            period_ack <= 1'b0;
            acc        <= acc_next;

            if (!enable) begin
                state <= StIdle;
                fref  <= 1'b0;
            end else if (go_high) begin
                state      <= StHigh;
                fref       <= 1'b1;
                rise       <= 1'b1;
                period_ack <= pend;
                period     <= p_next;
            end else if (go_low) begin
                state <= StLow;
                fref  <= 1'b0;
            end else if (go_stretch) begin
                state <= StStretch;
            end

            // A load on the application edge wins: it stays pending for the next boundary.
            if (load) begin
                pend     <= 1'b1;
                pend_val <= load_clamped;
            end else if (go_high) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ref_clk_gen.sv
module tb_ref_clk_gen;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [14:0] period_n;
    logic        load;
    logic        step_req;
    logic [7:0]  step_len;
    logic        fref;
    logic        rise;
    logic        period_ack;
    logic        pend;

    typedef struct {
        logic [3:0] v;  // {fref, rise, period_ack, pend}
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ref_clk_gen #(
        .N_W       (15),
        .DEFAULT_N (10),
        .S_W       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .period_n   (period_n),
        .load       (load),
        .step_req   (step_req),
        .step_len   (step_len),
        .fref       (fref),
        .rise       (rise),
        .period_ack (period_ack),
        .pend       (pend)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // One clock: strobes are sampled at the edge, dropped, and the expected
    // output of that edge is popped and compared.
    task automatic tick();
        exp_t       e;
        logic [3:0] obs;
        @(posedge clk);
        #1;
        load     = 1'b0;
        step_req = 1'b0;
        e   = sb.pop_front();
        obs = {fref, rise, period_ack, pend};
        n_tests++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed {fref,rise,ack,pend}=%b expected %b", e.tag, obs, e.v);
        end
    endtask

    // n cycles with constant fref/pend; rise and ack (if requested) only on the first.
    task automatic run(input int n, input logic f, input logic r, input logic a,
                       input logic p, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.v   = {f, r && (i == 0), a && (i == 0), p};
            e.tag = tag;
            sb.push_back(e);
            tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        period_n = '0;
        load     = 1'b0;
        step_req = 1'b0;
        step_len = '0;
        run(2, 0, 0, 0, 0, "reset");

        // 1: default period 5/5, no ack
        reset = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            run(5, 1, 1, 0, 0, "p10_hi");
            run(5, 0, 0, 0, 0, "p10_lo");
        end

        // 2: load 7 mid-HIGH, applies at the next boundary
        run(2, 1, 1, 0, 0, "p10_hi_a");
        load = 1'b1; period_n = 15'd7;
        run(3, 1, 0, 0, 1, "p10_hi_pend");
        run(5, 0, 0, 0, 1, "p10_lo_pend");
        run(4, 1, 1, 1, 0, "p7_hi_ack");
        run(3, 0, 0, 0, 0, "p7_lo");
        run(4, 1, 1, 0, 0, "p7_hi");
        run(3, 0, 0, 0, 0, "p7_lo2");

        // 3: load 0 then 1 -> clamped to 2, single ack
        run(1, 1, 1, 0, 0, "p7_hi_b");
        load = 1'b1; period_n = 15'd0;
        run(1, 1, 0, 0, 1, "ld0");
        load = 1'b1; period_n = 15'd1;
        run(2, 1, 0, 0, 1, "ld1");
        run(3, 0, 0, 0, 1, "ld1_lo");
        run(1, 1, 1, 1, 0, "p2_hi_ack");
        run(1, 0, 0, 0, 0, "p2_lo");
        run(1, 1, 1, 0, 0, "p2_hi");
        load = 1'b1; period_n = 15'd4;
        run(1, 0, 0, 0, 1, "p2_lo_ld4");
        // load on the application edge stays pending
        load = 1'b1; period_n = 15'd10;
        run(1, 1, 1, 1, 1, "p4_apply_ld10");
        run(1, 1, 0, 0, 1, "p4_hi");
        run(2, 0, 0, 0, 1, "p4_lo");
        run(5, 1, 1, 1, 0, "p10b_hi_ack");
        run(5, 0, 0, 0, 0, "p10b_lo");

        // 4: step of 3 stretches the low to 8; zero-length step ignored
        run(1, 1, 1, 0, 0, "st3_hi");
        step_req = 1'b1; step_len = 8'd3;
        run(4, 1, 0, 0, 0, "st3_hi2");
        run(8, 0, 0, 0, 0, "st3_lo8");
        run(1, 1, 1, 0, 0, "st0_hi");
        step_req = 1'b1; step_len = 8'd0;
        run(4, 1, 0, 0, 0, "st0_hi2");
        run(5, 0, 0, 0, 0, "st0_lo");
        // two steps of 200 saturate at 255; a step during stretch counts next period
        run(1, 1, 1, 0, 0, "sat_hi");
        step_req = 1'b1; step_len = 8'd200;
        run(1, 1, 0, 0, 0, "sat_hi2");
        step_req = 1'b1; step_len = 8'd200;
        run(3, 1, 0, 0, 0, "sat_hi3");
        run(15, 0, 0, 0, 0, "sat_lo_a");
        step_req = 1'b1; step_len = 8'd2;
        run(245, 0, 0, 0, 0, "sat_lo_b");
        run(5, 1, 1, 0, 0, "post_sat_hi");
        run(7, 0, 0, 0, 0, "post_sat_lo7");

        // 5: disable mid-HIGH with pending 12, re-enable applies it
        run(1, 1, 1, 0, 0, "dis_hi");
        load = 1'b1; period_n = 15'd12;
        run(1, 1, 0, 0, 1, "dis_ld12");
        enable = 1'b0;
        run(6, 0, 0, 0, 1, "disabled");
        enable = 1'b1;
        run(1, 1, 1, 1, 0, "p12_hi_ack");
        run(5, 1, 0, 0, 0, "p12_hi");
        run(6, 0, 0, 0, 0, "p12_lo");

        // 6: reset mid-LOW with pending load and step
        run(6, 1, 1, 0, 0, "rst_p12_hi");
        run(2, 0, 0, 0, 0, "rst_p12_lo");
        load = 1'b1; period_n = 15'd3;
        step_req = 1'b1; step_len = 8'd5;
        run(1, 0, 0, 0, 1, "rst_pre");
        reset = 1'b1;
        run(2, 0, 0, 0, 0, "rst_hold");
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            run(5, 1, 1, 0, 0, "post_rst_hi");
            run(5, 0, 0, 0, 0, "post_rst_lo");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ref_clk_gen.md
Name: ref_clk_gen

Overview:
Programmable reference-clock transmitter. It generates the square-wave reference `fin` that the PLL receives, with period expressed in `clk` cycles.
- Period changes are glitch-free and take effect only at period boundaries.
- Injected phase steps stretch the low phase, exercising the PLL's phase detector and K-counter loop.
- Sits beside the PLL top as on-chip stimulus and self-test source.

Parameters:
N_W, 15, width of period value (matches the PLL's multiplication-factor width)
DEFAULT_N, 10, period in clk cycles after reset
S_W, 8, width of phase-step length

Ports:
clk  input  1  system clock (10 MHz)
reset  input  1  synchronous reset, active-high
enable  input  1  high = generate; low = park output low
period_n  input  N_W  requested period in clk cycles
load  input  1  1-cycle strobe: capture period_n as pending
step_req  input  1  1-cycle strobe: request phase step
step_len  input  S_W  extra low cycles for the step
fref  output  1  generated reference (registered)
rise  output  1  1-cycle strobe on first high cycle of each period
period_ack  output  1  1-cycle strobe: pending period became active
pend  output  1  a period update is pending

Behaviour:
Interface:
- One clock, `clk`; `reset` is synchronous, active-high.
- `reset` overrides everything.

Reset values:
- fref=0, rise=0, period_ack=0, pend=0.
- Active period P=DEFAULT_N; pending register cleared; stretch accumulator 0; state IDLE.

Period arithmetic:
- Any period value <2 is clamped to 2 when captured.
- hi = P - (P>>1), i.e. ceil(P/2); lo = P>>1.
- Examples: P=10 gives 5/5; P=7 gives 4/3; P=2 gives 1/1.

FSM (states IDLE, HIGH, LOW, STRETCH):
- IDLE: fref=0. enable=1 sampled at cycle t -> HIGH, with fref=1 and rise=1 at t+1.
- HIGH: fref=1 for exactly hi cycles, then LOW.
- LOW: fref=0 for lo cycles. On the last cycle:
  - stretch accumulator >0 -> STRETCH;
  - else -> HIGH, applying any pending period.
- STRETCH: fref=0 for accumulator cycles. Then clear accumulator and -> HIGH, applying any pending period.
- enable=0 sampled in any state -> IDLE next cycle; fref=0 from that cycle. Pending period and stretch accumulator are retained.

Period update:
- load captures clamp(period_n) into pending and sets pend=1. A later load before application overwrites it; only one ack is issued.
- Application occurs on entry to HIGH from LOW/STRETCH. The new P governs that HIGH phase.
- On application: period_ack=1 coincident with rise; pend clears the same cycle.
- A load on the exact cycle of application is not applied then. It becomes pending (pend=1) for the next boundary.
- Entry to HIGH from IDLE also applies any pending period, with ack.

Phase step:
- step_req with step_len>0 adds step_len to the accumulator, saturating at 2^S_W-1.
- step_len=0 is ignored.
- A step_req during STRETCH accumulates for the following period.

Other outputs:
- rise is high only on the first HIGH cycle.
- No output is combinational from inputs; latency from any input to any output is 1 cycle minimum.

Decomposition:
- Shared package pll_pkg:
  - N_W and S_W constants;
  - state encoding IDLE/HIGH/LOW/STRETCH;
  - MIN_PERIOD=2.
- One natural sub-module: phase_timer, a loadable down-counter of N_W bits with load value and done pulse. It is reused for the HIGH, LOW and STRETCH durations.

Test Plan:
1. Reset, enable=1, no load -> fref 5 high / 5 low repeating; rise every 10 cycles; period_ack never asserts.
2. load period_n=7 mid-HIGH -> current 10-cycle period completes; period_ack and rise coincide; then 4 high / 3 low; pend 1 until ack.
3. load period_n=0, then period_n=1 before boundary -> single ack; period 2, fref toggles 1/1.
4. step_req step_len=3 during HIGH (P=10) -> following low lasts 8 cycles; next period normal 5/5. Two steps of 200 -> stretch saturates at 255.
5. enable=0 mid-HIGH with pending load=12 -> fref=0 next cycle, stays 0. Re-enable -> rise and period_ack together; 6 high / 6 low.
6. reset asserted mid-LOW with pending load and accumulated step -> all outputs 0 next cycle; pend=0; after enable, period=DEFAULT_N with no stretch and no ack.
